// File: rtl/pooling_controller_if.sv
// Buffer-side bus of the pooling scheduler: input-buffer read port and
// output-buffer write port.
//   rd_en/rd_addr : read strobe and element address (master drives)
//   rd_data       : read data, valid one cycle after rd_en (slave drives)
//   wr_en/wr_addr/wr_data : output-buffer write (master drives)
interface pooling_controller_if #(
    parameter int BITWIDTH  = 16,
    parameter int ADDRWIDTH = 16
);
    logic                 rd_en;
    logic [ADDRWIDTH-1:0] rd_addr;
    logic [BITWIDTH-1:0]  rd_data;
    logic                 wr_en;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [BITWIDTH-1:0]  wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/pooling_controller.sv
// Sequential max-pooling scheduler: walks the input map window by window,
// reduces each KHEIGHT x KWIDTH window with one shared signed comparator.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : run request, accepted only when idle
//   busy  : high during READ/WRITE cycles of a run
//   done  : one-cycle pulse in the FINISH cycle
//   bus   : master side of pooling_controller_if (buffer read/write ports)
module pooling_controller #(
    parameter int BITWIDTH   = 16,
    parameter int DATAWIDTH  = 28,
    parameter int DATAHEIGHT = 28,
    parameter int CHANNEL    = 1,
    parameter int KWIDTH     = 2,
    parameter int KHEIGHT    = 2,
    parameter int ADDRWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    pooling_controller_if.master bus
);

    localparam int OW = DATAWIDTH / KWIDTH;
    localparam int OH = DATAHEIGHT / KHEIGHT;
    localparam int AW = ADDRWIDTH;

    localparam logic [AW-1:0] L_DW   = AW'(DATAWIDTH);
    localparam logic [AW-1:0] L_KW   = AW'(KWIDTH);
    localparam logic [AW-1:0] L_KH   = AW'(KHEIGHT);
    localparam logic [AW-1:0] L_OW   = AW'(OW);
    localparam logic [AW-1:0] L_PIN  = AW'(DATAWIDTH * DATAHEIGHT);
    localparam logic [AW-1:0] L_POUT = AW'(OW * OH);
    localparam logic [AW-1:0] L_KW_M = AW'(KWIDTH - 1);
    localparam logic [AW-1:0] L_KH_M = AW'(KHEIGHT - 1);
    localparam logic [AW-1:0] L_OW_M = AW'(OW - 1);
    localparam logic [AW-1:0] L_OH_M = AW'(OH - 1);
    localparam logic [AW-1:0] L_CH_M = AW'(CHANNEL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    // Counters describe the element being read in the current cycle.
    logic [AW-1:0] r_ch, r_orow, r_ocol, r_kr, r_kc;
    logic [AW-1:0] w_ch, w_orow, w_ocol, w_kr, w_kc;

    logic                r_busy, r_done;
    logic                r_rd_en, r_wr_en;
    logic [AW-1:0]       r_rd_addr, r_wr_addr;
    logic [BITWIDTH-1:0] r_wr_data;

    // Read data returns one cycle late; these track what is on rd_data.
    logic                r_rd_v;
    logic                r_first;
    logic [BITWIDTH-1:0] r_acc;

    logic                w_last_elem;
    logic                w_last_win;
    logic [AW-1:0]       w_rd_addr;
    logic [AW-1:0]       w_wr_addr;
    logic [BITWIDTH-1:0] w_max;

    assign busy        = r_busy;
    assign done        = r_done;
    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;

    assign w_last_elem = (r_kr == L_KH_M) && (r_kc == L_KW_M);
    assign w_last_win  = (r_ch == L_CH_M) && (r_orow == L_OH_M)
                      && (r_ocol == L_OW_M);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_READ;
            S_READ:   if (w_last_elem) w_next = S_WRITE;
            S_WRITE:  w_next = w_last_win ? S_FINISH : S_READ;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        w_ch   = r_ch;
        w_orow = r_orow;
        w_ocol = r_ocol;
        w_kr   = r_kr;
        w_kc   = r_kc;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ch   = '0;
                    w_orow = '0;
                    w_ocol = '0;
                    w_kr   = '0;
                    w_kc   = '0;
                end
            end
            S_READ: begin
                // The last element wraps kr/kc to 0 for the next window.
                if (r_kc == L_KW_M) begin
                    w_kc = '0;
                    w_kr = w_last_elem ? '0 : r_kr + 1'b1;
                end else begin
                    w_kc = r_kc + 1'b1;
                end
            end
            S_WRITE: begin
                if (!w_last_win) begin
                    if (r_ocol == L_OW_M) begin
                        w_ocol = '0;
                        if (r_orow == L_OH_M) begin
                            w_orow = '0;
                            w_ch   = r_ch + 1'b1;
                        end else begin
                            w_orow = r_orow + 1'b1;
                        end
                    end else begin
                        w_ocol = r_ocol + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        w_rd_addr = w_ch * L_PIN
                  + (w_orow * L_KH + w_kr) * L_DW
                  + w_ocol * L_KW + w_kc;
        w_wr_addr = r_ch * L_POUT + r_orow * L_OW + r_ocol;

        // First element of a window loads unconditionally so all-negative
        // windows reduce to their true maximum.
        if (r_first || ($signed(bus.rd_data) > $signed(r_acc))) begin
            w_max = bus.rd_data;
        end else begin
            w_max = r_acc;
        end
    end

    // Registered outputs and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch      <= '0;
            r_orow    <= '0;
            r_ocol    <= '0;
            r_kr      <= '0;
            r_kc      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_v    <= 1'b0;
            r_first   <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_ch    <= w_ch;
            r_orow  <= w_orow;
            r_ocol  <= w_ocol;
            r_kr    <= w_kr;
            r_kc    <= w_kc;
            r_busy  <= (w_next == S_READ) || (w_next == S_WRITE);
            r_done  <= (w_next == S_FINISH);
            r_rd_en <= (w_next == S_READ);
            if (w_next == S_READ) begin
                r_rd_addr <= w_rd_addr;
            end
            // WRITE folds in the last element arriving this cycle, so the
            // write strobe leaves the cycle after WRITE.
            r_wr_en <= (r_state == S_WRITE);
            if (r_state == S_WRITE) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_max;
            end
            r_rd_v  <= (r_state == S_READ);
            r_first <= (r_state == S_READ) && (r_kr == '0) && (r_kc == '0);
            if (r_rd_v) begin
                r_acc <= w_max;
            end
        end
    end

endmodule

// File: tb/tb_pooling_controller.sv
// Bench for pooling_controller: three configurations (28x28, 4x4 with two
// channels, 5x5) against a window-level reference model.
module tb_pooling_controller;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start   [ND];
    logic        busy    [ND];
    logic        done    [ND];
    logic        rd_en   [ND];
    logic        wr_en   [ND];
    logic [15:0] rd_addr [ND];
    logic [15:0] wr_addr [ND];
    logic [15:0] wr_data [ND];
    logic [15:0] rd_data [ND];
    logic [15:0] mem [0:1023];

    always #5 clk = ~clk;

    pooling_controller_if #(.BITWIDTH(16), .ADDRWIDTH(16)) if0 ();
    pooling_controller_if #(.BITWIDTH(16), .ADDRWIDTH(16)) if1 ();
    pooling_controller_if #(.BITWIDTH(16), .ADDRWIDTH(16)) if2 ();

    pooling_controller u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .busy(busy[0]), .done(done[0]), .bus(if0.master)
    );

    pooling_controller #(
        .DATAWIDTH(4), .DATAHEIGHT(4), .CHANNEL(2)
    ) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .busy(busy[1]), .done(done[1]), .bus(if1.master)
    );

    pooling_controller #(
        .DATAWIDTH(5), .DATAHEIGHT(5), .CHANNEL(1)
    ) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .busy(busy[2]), .done(done[2]), .bus(if2.master)
    );

    assign rd_en[0]   = if0.rd_en;
    assign rd_addr[0] = if0.rd_addr;
    assign wr_en[0]   = if0.wr_en;
    assign wr_addr[0] = if0.wr_addr;
    assign wr_data[0] = if0.wr_data;
    assign if0.rd_data = rd_data[0];
    assign rd_en[1]   = if1.rd_en;
    assign rd_addr[1] = if1.rd_addr;
    assign wr_en[1]   = if1.wr_en;
    assign wr_addr[1] = if1.wr_addr;
    assign wr_data[1] = if1.wr_data;
    assign if1.rd_data = rd_data[1];
    assign rd_en[2]   = if2.rd_en;
    assign rd_addr[2] = if2.rd_addr;
    assign wr_en[2]   = if2.wr_en;
    assign wr_addr[2] = if2.wr_addr;
    assign wr_data[2] = if2.wr_data;
    assign if2.rd_data = rd_data[2];

    // Input buffer: one-cycle read latency per port.
    always @(posedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (rd_en[i]) rd_data[i] <= mem[rd_addr[i][9:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int a;
        int d;
    } ev_t;

    ev_t wq[$], rq[$], ew[$], er[$];
    int  dq[$], db[$];
    int  busy_n = 0;
    int  sel = 0;
    bit  mon_on = 1'b0;
    int  edone = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (wr_en[sel])
                wq.push_back('{cyc, int'(wr_addr[sel]), int'(wr_data[sel])});
            if (rd_en[sel])
                rq.push_back('{cyc, int'(rd_addr[sel]), 0});
            if (done[sel]) begin
                dq.push_back(cyc);
                db.push_back(int'(busy[sel]));
            end
            if (busy[sel]) busy_n++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h",
                   tag, idx, obs, exp);
        end
    endtask

    task automatic clr();
        wq.delete();
        rq.delete();
        dq.delete();
        db.delete();
        busy_n = 0;
    endtask

    // Reference: enumerate windows, take the signed max of each, and place
    // every access on the N+1 cycle-per-window schedule.
    task automatic model(input int W, input int H, input int C);
        int ow, oh, n, k, a;
        logic signed [15:0] m, v;
        ow = W / 2;
        oh = H / 2;
        n  = 4;
        k  = 0;
        ew.delete();
        er.delete();
        for (int ch = 0; ch < C; ch++)
            for (int orw = 0; orw < oh; orw++)
                for (int oc = 0; oc < ow; oc++) begin
                    m = '0;
                    for (int kr = 0; kr < 2; kr++)
                        for (int kc = 0; kc < 2; kc++) begin
                            a = ch * H * W + (orw * 2 + kr) * W + oc * 2 + kc;
                            v = mem[a];
                            if ((kr == 0 && kc == 0) || v > m) m = v;
                            er.push_back('{1 + k * (n + 1) + kr * 2 + kc, a, 0});
                        end
                    ew.push_back('{(k + 1) * (n + 1) + 1,
                                   ch * oh * ow + orw * ow + oc,
                                   int'({16'b0, m})});
                    k++;
                end
        edone = 1 + k * (n + 1);
    endtask

    task automatic run(input int s, input int W, input int H, input int C,
                       input bit again);
        int t0, n;
        model(W, H, C);
        sel = s;
        clr();
        tick();
        mon_on = 1'b1;
        start[s] = 1'b1;
        t0 = cyc;
        tick();
        start[s] = 1'b0;
        n = 0;
        while (dq.size() == 0 && n < edone + 20) begin
            tick();
            n++;
            start[s] = again && (cyc - t0 == 7);
        end
        start[s] = 1'b0;
        repeat (5) tick();
        mon_on = 1'b0;
        chk("done_count", s, dq.size(), 1);
        if (dq.size() > 0) begin
            chk("done_cycle", s, dq[0] - t0, edone);
            chk("busy_at_done", s, db[0], 0);
        end
        chk("busy_cycles", s, busy_n, edone - 1);
        chk("wr_count", s, wq.size(), ew.size());
        for (int i = 0; i < wq.size() && i < ew.size(); i++) begin
            chk("wr_addr", i, wq[i].a, ew[i].a);
            chk("wr_data", i, wq[i].d, ew[i].d);
            chk("wr_cycle", i, wq[i].c - t0, ew[i].c);
        end
        chk("rd_count", s, rq.size(), er.size());
        for (int i = 0; i < rq.size() && i < er.size(); i++) begin
            chk("rd_addr", i, rq[i].a, er[i].a);
            chk("rd_cycle", i, rq[i].c - t0, er[i].c);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    endtask

    initial begin
        int t0, bad;
        for (int i = 0; i < ND; i++) start[i] = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < ND; i++) begin
            chk("rst_busy", i, busy[i], 0);
            chk("rst_done", i, done[i], 0);
            chk("rst_rd_en", i, rd_en[i], 0);
            chk("rst_wr_en", i, wr_en[i], 0);
            chk("rst_rd_addr", i, rd_addr[i], 0);
            chk("rst_wr_addr", i, wr_addr[i], 0);
            chk("rst_wr_data", i, wr_data[i], 0);
        end
        rst = 1'b0;
        tick();

        // 4x4, 2 channels, data = address index.
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        run(1, 4, 4, 2, 1'b0);
        if (wq.size() >= 8) begin
            chk("idx_max0", 0, wq[0].d, 5);
            chk("idx_max1", 1, wq[1].d, 7);
            chk("idx_max2", 2, wq[2].d, 13);
            chk("idx_max3", 3, wq[3].d, 15);
            chk("ch1_wr_addr", 4, wq[4].a, 4);
        end
        if (rq.size() > 16) chk("ch1_rd_addr", 16, rq[16].a, 16);

        // All-negative window, signed extremes, start pulsed while busy.
        fill_random();
        mem[0] = 16'hFFFD;
        mem[1] = 16'hFFFF;
        mem[4] = 16'hFFF9;
        mem[5] = 16'hFFFE;
        mem[2] = 16'h8000;
        mem[3] = 16'h7FFF;
        mem[6] = 16'h8000;
        mem[7] = 16'h8000;
        run(1, 4, 4, 2, 1'b1);
        if (wq.size() >= 2) begin
            chk("neg_max", 0, wq[0].d, 32'h0000FFFF);
            chk("signed_max", 1, wq[1].d, 32'h00007FFF);
        end

        // 5x5: trailing row/column never read.
        fill_random();
        run(2, 5, 5, 1, 1'b0);
        bad = 0;
        foreach (rq[i]) begin
            if ((rq[i].a / 5) == 4 || (rq[i].a % 5) == 4) bad++;
        end
        chk("odd_edge_reads", 0, bad, 0);

        // Default 28x28 map.
        fill_random();
        run(0, 28, 28, 1, 1'b0);

        // Reset in the middle of the second window's reads.
        fill_random();
        sel = 1;
        clr();
        tick();
        mon_on = 1'b1;
        start[1] = 1'b1;
        t0 = cyc;
        tick();
        start[1] = 1'b0;
        while (cyc - t0 < 7) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 0, busy[1], 0);
        chk("abort_done", 0, done[1], 0);
        chk("abort_rd_en", 0, rd_en[1], 0);
        chk("abort_wr_en", 0, wr_en[1], 0);
        chk("abort_rd_addr", 0, rd_addr[1], 0);
        chk("abort_wr_addr", 0, wr_addr[1], 0);
        chk("abort_wr_data", 0, wr_data[1], 0);
        rst = 1'b0;
        repeat (40) tick();
        mon_on = 1'b0;
        chk("abort_wr_count", 0, wq.size(), 1);
        chk("abort_done_count", 0, dq.size(), 0);
        run(1, 4, 4, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
